// File: rtl/key_cmd_pkg.sv
// key_cmd_pkg
//  Shared definitions for the keyboard command path: 4-bit game command codes,
//  the ASCII key bytes they correspond to, the transmitter FSM state type and
//  the command-to-key mapping function. The key receive path uses the same
//  constants, so the two directions always agree on the encoding.
//  Optional build macro: KEY_TX_PARITY_EN (adds the PARITY state).
package key_cmd_pkg;

  // Game command codes; 0 and 8..15 are unmapped
  localparam logic [3:0] CMD_NONE  = 4'd0;
  localparam logic [3:0] CMD_UP    = 4'd1;
  localparam logic [3:0] CMD_LEFT  = 4'd2;
  localparam logic [3:0] CMD_DOWN  = 4'd3;
  localparam logic [3:0] CMD_RIGHT = 4'd4;
  localparam logic [3:0] CMD_FIRE  = 4'd5;
  localparam logic [3:0] CMD_ENTER = 4'd6;
  localparam logic [3:0] CMD_PAUSE = 4'd7;

  // ASCII key bytes
  localparam logic [7:0] KEY_W     = 8'h77;
  localparam logic [7:0] KEY_A     = 8'h61;
  localparam logic [7:0] KEY_S     = 8'h73;
  localparam logic [7:0] KEY_D     = 8'h64;
  localparam logic [7:0] KEY_SPACE = 8'h20;
  localparam logic [7:0] KEY_ENTER = 8'h0D;
  localparam logic [7:0] KEY_P     = 8'h70;

  // Transmitter states; PARITY only exists in parity builds
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef KEY_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

  // Result of a command lookup: valid is low for unmapped codes
  typedef struct packed {
    logic       valid;
    logic [7:0] key;
  } key_map_t;

  // Pure command-to-key mapping, the inverse of the receive-side decode
  function automatic key_map_t cmdToKey(input logic [3:0] code);
    key_map_t m;
    m.valid = 1'b1;
    m.key   = 8'h00;
    case (code)
      CMD_UP:    m.key = KEY_W;
      CMD_LEFT:  m.key = KEY_A;
      CMD_DOWN:  m.key = KEY_S;
      CMD_RIGHT: m.key = KEY_D;
      CMD_FIRE:  m.key = KEY_SPACE;
      CMD_ENTER: m.key = KEY_ENTER;
      CMD_PAUSE: m.key = KEY_P;
      default:   m.valid = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen
//  Bit-period timer. Counts 0..CLKS_PER_BIT-1 and raises tick for one cycle in
//  the last cycle of each bit period, then wraps. While clear is high the
//  counter is held at 0 and no tick is produced, so the first bit after clear
//  drops lasts exactly CLKS_PER_BIT cycles.
//  Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   clear  in  1  hold counter at zero
//   tick   out 1  last cycle of the current bit period
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

  logic [15:0] baudCnt;

  // Free-running bit counter; wraps at the end of each bit, parked at 0 by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baudCnt <= 16'd0;
    end else if (clear || baudCnt == LAST_COUNT) begin
      baudCnt <= 16'd0;
    end else begin
      baudCnt <= baudCnt + 16'd1;
    end
  end

  // The tick is combinational so the FSM can act on the very cycle the bit ends
  always_comb begin
    tick = !clear && (baudCnt == LAST_COUNT);
  end

endmodule

// File: rtl/key_cmd_uart_tx.sv
// key_cmd_uart_tx
//  Maps a 4-bit game command to its ASCII key byte and sends it as one UART
//  frame (start, 8 data bits LSB first, optional even parity, stop).
//  Build macro: KEY_TX_PARITY_EN inserts an even-parity bit before the stop bit.
//  Ports:
//   clk        in  1  system clock
//   rst_n      in  1  asynchronous active-low reset
//   cmd        in  4  command code, sampled on cmd_valid && cmd_ready
//   cmd_valid  in  1  send request
//   cmd_ready  out 1  high while idle
//   tx         out 1  serial line, idles high
//   done       out 1  pulse in the last cycle of the stop bit
//   err        out 1  pulse the cycle after an unmapped command is accepted
module key_cmd_uart_tx
  import key_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       tx,
  output logic       done,
  output logic       err
);

  tx_state_t   state;
  tx_state_t   stateNext;
  logic [2:0]  bitIdx;
  logic [7:0]  dataByte;
  logic        bitTick;
  logic        accept;
  logic        loadByte;
  logic        errSet;
  key_map_t    cmdMap;

  // The timer only runs while a frame is on the line
  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state == IDLE),
    .tick (bitTick)
  );

  // State register plus the datapath registers it steers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bitIdx   <= 3'd0;
      dataByte <= 8'h00;
      err      <= 1'b0;
    end else begin
      state <= stateNext;
      err   <= errSet;
      if (loadByte) begin
        dataByte <= cmdMap.key;
      end
      if (state == IDLE) begin
        bitIdx <= 3'd0;
      end else if (state == DATA && bitTick) begin
        bitIdx <= bitIdx + 3'd1;
      end
    end
  end

  // Next-state and output decode; tx comes straight from state so an async
  // reset pulls the line high in the same cycle
  always_comb begin
    stateNext = state;
    loadByte  = 1'b0;
    errSet    = 1'b0;
    cmd_ready = 1'b0;
    tx        = 1'b1;
    done      = 1'b0;
    cmdMap    = cmdToKey(cmd);
    accept    = cmd_valid && (state == IDLE);
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (accept) begin
          if (cmdMap.valid) begin
            loadByte  = 1'b1;
            stateNext = START;
          end else begin
            errSet = 1'b1;
          end
        end
      end
      START: begin
        tx = 1'b0;
        if (bitTick) begin
          stateNext = DATA;
        end
      end
      DATA: begin
        tx = dataByte[bitIdx];
        if (bitTick && bitIdx == 3'd7) begin
`ifdef KEY_TX_PARITY_EN
          stateNext = PARITY;
`else
          stateNext = STOP;
`endif
        end
      end
`ifdef KEY_TX_PARITY_EN
      PARITY: begin
        tx = ^dataByte;
        if (bitTick) begin
          stateNext = STOP;
        end
      end
`endif
      STOP: begin
        tx = 1'b1;
        if (bitTick) begin
          done      = 1'b1;
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_key_cmd_uart_tx.sv
// tb_key_cmd_uart_tx
//  Directed bench for key_cmd_uart_tx with CLKS_PER_BIT=4. Expected frames are
//  built from hand-written key bytes and the frame layout; the optional parity
//  case is compiled in when KEY_TX_PARITY_EN is defined.
module tb_key_cmd_uart_tx;

  localparam int CPB = 4;
`ifdef KEY_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       tx;
  logic       done;
  logic       err;

  int checkCount;
  int errorCount;

  key_cmd_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .tx       (tx),
    .done     (done),
    .err      (err)
  );

  // 100 MHz-style clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something upstream hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] c, input logic v);
    cmd       = c;
    cmd_valid = v;
  endtask

  // Advance to just after the next rising edge
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 1 after the accept edge; walks the whole frame and ends in
  // the first idle cycle. With wiggle set, cmd is changed mid-frame.
  task automatic expectFrame(input logic [7:0] key, input bit wiggle);
    int   lastCycle;
    int   pos;
    logic expTx;
    lastCycle = FRAME_BITS * CPB;
    for (int k = 1; k <= lastCycle; k++) begin
      pos = (k - 1) / CPB;
      if (pos == 0) expTx = 1'b0;
      else if (pos <= 8) expTx = key[pos-1];
      else if (pos == FRAME_BITS - 1) expTx = 1'b1;
      else expTx = ^key;
      checkOutput($sformatf("frame%02h_c%0d", key, k), {29'd0, tx, cmd_ready, done},
                  {29'd0, expTx, 1'b0, (k == lastCycle)});
      if (wiggle && k == 10) cmd = ~cmd;
      stepCycle();
    end
    checkOutput($sformatf("frame%02h_idle", key), {30'd0, tx, cmd_ready}, 32'h3);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    applyStimulus(4'd0, 1'b0);
    #2;
    checkOutput("reset", {28'd0, tx, cmd_ready, done, err}, 32'hC);
    #10;
    rst_n = 1'b1;

    // 1: idle hold
    for (int i = 0; i < 100; i++) begin
      stepCycle();
      checkOutput($sformatf("idle_%0d", i), {28'd0, tx, cmd_ready, done, err}, 32'hC);
    end

    // 2: single 'w' frame
    $display("[TB] cmd=1 frame");
    applyStimulus(4'd1, 1'b1);
    stepCycle();
    applyStimulus(4'd0, 1'b0);
    expectFrame(8'h77, 1'b0);

    // 3: unmapped commands
    $display("[TB] unmapped commands");
    applyStimulus(4'd0, 1'b1);
    stepCycle();
    applyStimulus(4'd0, 1'b0);
    checkOutput("err0_pulse", {28'd0, tx, cmd_ready, done, err}, 32'hD);
    stepCycle();
    checkOutput("err0_clear", {28'd0, tx, cmd_ready, done, err}, 32'hC);
    applyStimulus(4'd9, 1'b1);
    stepCycle();
    applyStimulus(4'd0, 1'b0);
    checkOutput("err9_pulse", {28'd0, tx, cmd_ready, done, err}, 32'hD);
    stepCycle();
    checkOutput("err9_clear", {28'd0, tx, cmd_ready, done, err}, 32'hC);

    // 4: back-to-back with valid held, cmd changing mid-frame
    $display("[TB] back-to-back frames");
    applyStimulus(4'd2, 1'b1);
    stepCycle();
    applyStimulus(4'd4, 1'b1);
    expectFrame(8'h61, 1'b0);
    stepCycle();
    applyStimulus(4'd4, 1'b0);
    expectFrame(8'h64, 1'b1);

    // 5: reset during data bit 3 of a space frame
    $display("[TB] reset mid-frame");
    applyStimulus(4'd5, 1'b1);
    stepCycle();
    applyStimulus(4'd0, 1'b0);
    repeat (17) stepCycle();
    checkOutput("prereset_bit3", {31'd0, tx}, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", {28'd0, tx, cmd_ready, done, err}, 32'hC);
    #1;
    rst_n = 1'b1;
    stepCycle();
    checkOutput("after_reset", {28'd0, tx, cmd_ready, done, err}, 32'hC);
    applyStimulus(4'd6, 1'b1);
    stepCycle();
    applyStimulus(4'd0, 1'b0);
    expectFrame(8'h0D, 1'b0);

`ifdef KEY_TX_PARITY_EN
    // 6: parity frame for 'p'
    $display("[TB] parity frame");
    applyStimulus(4'd7, 1'b1);
    stepCycle();
    applyStimulus(4'd0, 1'b0);
    expectFrame(8'h70, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
